// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates active-low row strobes, debounces the
// active-low column returns and reports one key code per press.
module keypad_scan #(
   parameter int unsigned SCAN_DIV = 25_000,
   parameter int unsigned DB_CNT   = 8
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = $clog2(DB_CNT + 1);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

   state_e          state_q;
   logic [DW-1:0]   div_q;
   logic [CW-1:0]   db_cnt_q;
   logic [CW-1:0]   rel_cnt_q;
   logic [3:0]      col_meta_q;
   logic [3:0]      col_s;
   logic [3:0]      cand_q;
   logic            tick;
   logic            hit;
   logic [1:0]      col_idx;
   logic [1:0]      row_idx;

   assign tick = (div_q == DW'(SCAN_DIV - 1));
   assign hit  = (col_s != 4'b1111);

   // Lowest-numbered low column wins.
   always_comb begin
      col_idx = 2'd0;
      if (!col_s[0])      col_idx = 2'd0;
      else if (!col_s[1]) col_idx = 2'd1;
      else if (!col_s[2]) col_idx = 2'd2;
      else if (!col_s[3]) col_idx = 2'd3;
   end

   // Decode the one-hot-low row strobe into an index.
   always_comb begin
      row_idx = 2'd0;
      case (row)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
   end

   // Two-flop synchronizer for the asynchronous column inputs.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q <= 4'b1111;
         col_s      <= 4'b1111;
      end else begin
         col_meta_q <= col;
         col_s      <= col_meta_q;
      end
   end

   // Free-running scan divider; tick marks its terminal count.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DW'(1);
      end
   end

   // Scan/debounce/hold state machine with registered outputs.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StScan;
         row       <= 4'b1110;
         db_cnt_q  <= '0;
         rel_cnt_q <= '0;
         cand_q    <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (tick) begin
            unique case (state_q)
               StScan: begin
                  if (!hit) begin
                     row <= {row[2:0], row[3]};
                  end else if (DB_CNT == 1) begin
                     // Single-tick debounce: accept on first sighting.
                     cand_q    <= {row_idx, col_idx};
                     key_code  <= {row_idx, col_idx};
                     key_valid <= 1'b1;
                     key_down  <= 1'b1;
                     rel_cnt_q <= '0;
                     state_q   <= StHeld;
                  end else begin
                     cand_q   <= {row_idx, col_idx};
                     db_cnt_q <= CW'(1);
                     state_q  <= StDebounce;
                  end
               end
               StDebounce: begin
                  if (hit && (col_idx == cand_q[1:0])) begin
                     if ((db_cnt_q + CW'(1)) == CW'(DB_CNT)) begin
                        key_code  <= cand_q;
                        key_valid <= 1'b1;
                        key_down  <= 1'b1;
                        rel_cnt_q <= '0;
                        db_cnt_q  <= '0;
                        state_q   <= StHeld;
                     end else begin
                        db_cnt_q <= db_cnt_q + CW'(1);
                     end
                  end else begin
                     db_cnt_q <= '0;
                     row      <= {row[2:0], row[3]};
                     state_q  <= StScan;
                  end
               end
               StHeld: begin
                  // Release needs DB_CNT consecutive all-high ticks on the held row.
                  if (hit) begin
                     rel_cnt_q <= '0;
                  end else if ((rel_cnt_q + CW'(1)) == CW'(DB_CNT)) begin
                     rel_cnt_q <= '0;
                     key_down  <= 1'b0;
                     row       <= {row[2:0], row[3]};
                     state_q   <= StScan;
                  end else begin
                     rel_cnt_q <= rel_cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_q <= StScan;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DB_CNT=3. Edge E_k is the
// k-th rising edge after reset release; ticks are evaluated on E4, E8, E12...
module tb_keypad_scan;

   logic       clk_in;
   logic       rst_n;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;

   int unsigned n_cmp;
   int unsigned n_bad;
   int unsigned ecnt;
   int unsigned vcnt;
   int unsigned mode;

   keypad_scan #(
      .SCAN_DIV(4),
      .DB_CNT  (3)
   ) u_dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .col      (col),
      .row      (row),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_down (key_down)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Keypad model: which keys are pressed, seen through the driven row.
   always_comb begin
      col = 4'b1111;
      case (mode)
         1: if (row == 4'b1011) col = 4'b1101;
         2: if (row == 4'b1101) col = 4'b0110;
         3: if (row == 4'b1101) col = 4'b0100;
         default: col = 4'b1111;
      endcase
   end

   // Edge counter since the last reset release.
   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   // Count key_valid pulses.
   always @(posedge clk_in) begin
      if (key_valid) vcnt <= vcnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to 1 time unit past edge E_n.
   task automatic wait_edge(input int unsigned n);
      int unsigned guard = 0;
      while (ecnt < n && guard < 1000) begin
         @(posedge clk_in);
         #1;
         guard++;
      end
      if (ecnt != n) check("edge_sync", ecnt, n);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      vcnt  = 0;
      mode  = 0;
      rst_n = 1'b0;
      #12;
      // 1: reset values
      check("rst_row", row, 4'b1110);
      check("rst_code", key_code, 4'd0);
      check("rst_valid", key_valid, 1'b0);
      check("rst_down", key_down, 1'b0);
      #10 rst_n = 1'b1;  // released at t=22, E1 at t=25

      wait_edge(3);  check("scan_e3", row, 4'b1110);
      wait_edge(4);  check("scan_e4", row, 4'b1101);
      wait_edge(8);  check("scan_e8", row, 4'b1011);
      wait_edge(12); check("scan_e12", row, 4'b0111);
      wait_edge(16); check("scan_e16", row, 4'b1110);

      // 2: press key 9 (row 2, col 1)
      mode = 1;
      wait_edge(27);
      check("p9_row", row, 4'b1011);
      check("p9_novalid", vcnt, 0);
      check("p9_down0", key_down, 1'b0);
      wait_edge(35);
      check("p9_early", key_valid, 1'b0);
      wait_edge(36);
      check("p9_valid", key_valid, 1'b1);
      check("p9_code", key_code, 4'd9);
      check("p9_down", key_down, 1'b1);
      check("p9_rowhold", row, 4'b1011);
      wait_edge(37);
      check("p9_pulse1", key_valid, 1'b0);
      check("p9_vcnt", vcnt, 1);

      // 4: release; key_down falls on the third idle tick (E52)
      wait_edge(40);
      mode = 0;
      wait_edge(51);
      check("rel_still", key_down, 1'b1);
      check("rel_rowhold", row, 4'b1011);
      wait_edge(52);
      check("rel_down", key_down, 1'b0);
      check("rel_row", row, 4'b0111);
      check("rel_code", key_code, 4'd9);

      // 3: bounce on row 2 for one tick
      wait_edge(62);
      mode = 1;
      wait_edge(68);
      mode = 0;
      wait_edge(71);
      check("bnc_hold", row, 4'b1011);
      wait_edge(72);
      check("bnc_row", row, 4'b0111);
      check("bnc_down", key_down, 1'b0);
      check("bnc_vcnt", vcnt, 1);
      wait_edge(76);
      check("bnc_scan", row, 4'b1110);

      // 5: two keys on row 1, col 0 wins -> code 4
      mode = 2;
      wait_edge(91);
      check("p4_early", key_valid, 1'b0);
      wait_edge(92);
      check("p4_valid", key_valid, 1'b1);
      check("p4_code", key_code, 4'd4);
      wait_edge(93);
      check("p4_pulse1", key_valid, 1'b0);
      mode = 3;
      wait_edge(110);
      check("p4_vcnt", vcnt, 2);
      check("p4_down", key_down, 1'b1);
      check("p4_row", row, 4'b1101);

      // 6: asynchronous reset in HELD
      #3 rst_n = 1'b0;
      #1;
      check("ar_row", row, 4'b1110);
      check("ar_code", key_code, 4'd0);
      check("ar_valid", key_valid, 1'b0);
      check("ar_down", key_down, 1'b0);
      mode = 0;
      @(negedge clk_in);
      #2 rst_n = 1'b1;
      wait_edge(3);
      check("ar_e3", row, 4'b1110);
      wait_edge(4);
      check("ar_e4", row, 4'b1101);
      check("ar_vcnt", vcnt, 2);
      check("ar_down2", key_down, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad. Drives active-low row strobes in rotation and reads four active-low, pulled-up column lines.
- Debounces presses and releases, then reports one 4-bit key code per press.
- Forms the input side of the board user interface. It pairs with the multiplexed seven-segment output: the same time-multiplexed select technique, used for reading instead of driving.

Parameters:
- SCAN_DIV, 25_000, clk_in cycles per scan tick; one row is held per tick. Legal range is 2 or more.
- DB_CNT, 8, consecutive agreeing ticks needed to accept a press or a release. Legal range is 1 or more.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- col  input  4  keypad columns, active-low, asynchronous to clk_in.
- row  output  4  row strobes, active-low, one-hot-low.
- key_code  output  4  last accepted key, equal to row_idx*4 + col_idx.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_down  output  1  high while the accepted key is held.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n is asynchronous and active-low; all flops are cleared by it.
- Reset values:
  - row = 4'b1110 (row 0).
  - key_code = 0, key_valid = 0, key_down = 0.
  - State = SCAN.
  - Divider, db_cnt and rel_cnt = 0.
  - Column synchronizer flops = 4'b1111.
- Column synchronizer: col passes through a 2-flop synchronizer to give col_s. All decisions use col_s.
- Tick generation:
  - The divider counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted for one cycle when the divider equals SCAN_DIV-1.
  - The divider free-runs in every state.
- Column index: hit means col_s != 4'b1111. col_idx is the index of the lowest-numbered low bit (col 0 has highest priority).
- Row advance: rotates the low bit upward, 1110 -> 1101 -> 1011 -> 0111 -> 1110. The new row value is registered on the tick cycle itself.
- State SCAN (on tick):
  - No hit: advance the row.
  - Hit: latch cand = {row_idx, col_idx}, set db_cnt = 1 and go to DEBOUNCE. The row is not advanced.
  - If DB_CNT == 1, go directly to accept instead.
- State DEBOUNCE (on tick, same row held):
  - Hit with the same col_idx: db_cnt increments. When it reaches DB_CNT, accept.
  - Otherwise (no hit, or a different col_idx): db_cnt = 0, advance the row and return to SCAN.
  - No key_valid is produced on this path.
- Accept (single cycle, the tick cycle):
  - key_code <= cand, key_valid = 1 for exactly that cycle, key_down <= 1.
  - rel_cnt = 0, go to HELD.
- State HELD (row held, on tick):
  - No hit: rel_cnt increments. Any hit: rel_cnt = 0.
  - When rel_cnt reaches DB_CNT: key_down <= 0, advance the row, go to SCAN.
  - key_code retains its value after release.
- Multiple simultaneous keys:
  - Same row: the lowest column wins.
  - Different rows: the first row reached in scan order wins.
  - Other keys are ignored while in HELD; release requires all columns high on the held row.
- key_valid never asserts on two consecutive cycles. At most one pulse per press and release cycle.
- Latency: a stable press is accepted 2 sync cycles plus a wait for the row's tick, plus (DB_CNT-1) further ticks.
- Reset mid-operation (any state): immediate return to reset values. Any partial debounce is discarded.

Test Plan (SCAN_DIV=4, DB_CNT=3):
1. Reset, col=1111 -> row=1110, key_code=0, key_valid=0, key_down=0. Row steps 1101, 1011, 0111, 1110 every 4 clocks.
2. Pull col=1101 whenever row==1011, held -> enters DEBOUNCE on row 2. After 3 agreeing ticks: one-cycle key_valid, key_code=9, key_down=1, row stays 1011.
3. Bounce: col=1101 on row 2 for 1 tick, then 1111 -> no key_valid, key_down stays 0, row advances to 0111 and scanning continues.
4. From test 2, release col=1111 -> key_down falls after exactly 3 idle ticks, row advances to 0111, key_code remains 9.
5. Row 1 with col=0110 (col0 and col3 low) -> key_code=4 with a single key_valid pulse. Then hold col=0110 while driving another column low -> no further key_valid.
6. Assert rst_n=0 mid-HELD, asynchronously between clock edges -> outputs go to reset values immediately. After release of reset with col=1111, scanning resumes from row=1110 with no stale key_valid.
